coherence_bus_ctrl: RTL and testbench
=====================================

Name: coherence_bus_ctrl

Overview:
- Two-core memory/coherence controller; sits between two icache/dcache pairs and the single-ported RAM.
- Arbitrates instruction fetches, dcache writebacks and dcache coherence transactions.
- Snoops the non-requesting dcache (MSI-style invalidate) and performs cache-to-cache transfers with a simultaneous memory update.
- All data blocks are two words, 8-byte aligned.

Parameters:
- ADDR_W, 32, address/data width in bits.
- CPUS, 2, number of cores; fixed at 2 (other index = ~c).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- iREN  in  2  per-core instruction read request.
- iaddr  in  2x32  per-core instruction address.
- iwait  out  2  per-core instruction wait; 0 = iload valid this cycle.
- iload  out  2x32  instruction read data.
- dREN  in  2  per-core dcache memory read.
- dWEN  in  2  per-core dcache memory write.
- daddr  in  2x32  dcache address.
- dstore  in  2x32  dcache write data; also carries snoop-response data.
- cctrans  in  2  coherence transaction request; held high for the whole transaction.
- ccwrite  in  2  snooped cache holds the block dirty (response).
- dwait  out  2  dcache wait; 0 = access complete this cycle.
- dload  out  2x32  dcache read data.
- ccwait  out  2  snoop request to the cache.
- ccinv  out  2  invalidate the snooped block.
- ccsnoopaddr  out  2x32  snoop address.
- ramREN  out  1  RAM read.
- ramWEN  out  1  RAM write.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ram_ready  in  1  RAM access completes this cycle.

Behaviour:
- Reset: state=IDLE, last_grant=1, req=0, wcount=0.
- Reset outputs: all iwait/dwait=1, ccwait=0, ccinv=0, ramREN=0, ramWEN=0, addresses/data=0.
- Reset mid-transaction aborts immediately, with no RAM write issued.
- Default outputs every cycle: iwait=dwait=2'b11, ccwait=ccinv=0, ram enables 0.
- dload/iload are driven from ramload unless stated otherwise.

IDLE — priority, decided combinationally; a grant registers req and moves state the next cycle:
- (1) cctrans → SNOOP.
- (2) dWEN without cctrans → DWB (writeback).
- (3) dREN without cctrans → DRD.
- (4) iREN → IFETCH.
- Within one class, a single requester wins. If both cores request, the winner is ~last_grant; last_grant updates on each grant.
- No combinational request→RAM path in IDLE: minimum 1 cycle of arbitration latency.

SNOOP:
- Drive ccwait[~req]=1, ccsnoopaddr[~req]=daddr[req]&~7, ccinv[~req]=dWEN[req] (write miss/upgrade). ccinv must be held until leaving the transaction.
- The state lasts exactly 1 cycle (the snooped cache responds registered).
- Next state: ccwrite[~req] → C2C; else if dREN[req] → DRD_T; else (upgrade, no data) → ACK.

C2C (wcount 0,1):
- ccwait[~req] held.
- ramWEN=1, ramaddr={blk,wcount,2'b00}, ramstore=dstore[~req], dload[req]=dstore[~req].
- On ram_ready: dwait[req]=0, dwait[~req]=0, wcount++.
- After word 1: wcount=0 → IDLE.
- Requester's dWEN is ignored during C2C.

DRD_T / DRD / DWB:
- Pass-through: ramREN=dREN[req], ramWEN=dWEN[req], ramaddr=daddr[req], ramstore=dstore[req], dwait[req]=~ram_ready.
- DRD_T (cctrans-held read): returns to IDLE when cctrans[req] drops. Any number of accesses is allowed; the requester controls the word count.
- DRD/DWB: return to IDLE the cycle after ram_ready.

ACK:
- dwait[req]=0 for exactly 1 cycle, then wait for cctrans[req]=0 → IDLE.

IFETCH:
- ramREN=1, ramaddr=iaddr[req], iwait[req]=~ram_ready; on ram_ready → IDLE.

Boundary conditions:
- Simultaneous cctrans from both cores: one serialized; the loser sees dwait=1 and is snooped by the winner's transaction first.
- A cache being snooped must not start its own cctrans until ccwait drops.
- Request deasserted in IDLE before grant: no effect.
- Requester deasserts during a pass-through state: return to IDLE with no RAM enables that cycle.
- last_grant toggles only on an actual grant.

Test Plan:
- Core0 iREN, iaddr=0x100, RAM ready after 2 cycles with ramload=0xDEADBEEF → ramREN, ramaddr=0x100; iwait[0]=0 and iload=0xDEADBEEF on the ready cycle; back to IDLE.
- Both cores iREN in the same cycle, last_grant=1 → core0 served first, then core1; a second simultaneous pair → core0 first again (last_grant=1 after core1).
- Core0 cctrans+dREN at 0x40, core1 dirty (ccwrite=1) with dstore 0x11 then 0x22 → ccwait[1], ccsnoopaddr[1]=0x40, ccinv[1]=0; RAM writes 0x40←0x11 and 0x44←0x22; dload[0] matches; both dwait pulse per word.
- Core1 cctrans+dWEN (upgrade) at 0x88, core0 clean → ccinv[0]=1, ccsnoopaddr[0]=0x88, no RAM access, dwait[1]=0 for one cycle, IDLE after cctrans drops.
- Core0 dWEN writeback 0x200←0x5 with core1 iREN pending → writeback granted first, then ifetch.
- Assert RST during C2C word 0 → all outputs return to reset values asynchronously; no ramWEN on the following cycle.

Source files
------------

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl
//   Two-core memory/coherence controller between two icache/dcache pairs
//   and a single-ported RAM. Arbitrates instruction fetches, dcache
//   writebacks/reads and dcache coherence transactions. It snoops the
//   non-requesting dcache (MSI invalidate) and performs cache-to-cache
//   transfers while updating memory. Blocks are two words, 8-byte aligned.
//
// Ports
//   CLK, RST                 clock, asynchronous active-high reset
//   iREN/iaddr               per-core instruction read request/address
//   iwait/iload              per-core instruction wait (0 = data valid) and data
//   dREN/dWEN/daddr/dstore   per-core dcache read/write/address/data
//                            (dstore also carries snoop-response data)
//   cctrans/ccwrite          coherence transaction request / dirty snoop response
//   dwait/dload              per-core dcache wait (0 = complete) and read data
//   ccwait/ccinv/ccsnoopaddr snoop request, invalidate and address to a cache
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ram_ready  RAM interface
module coherence_bus_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CPUS   = 2
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [CPUS-1:0]                iREN,
    input  logic [CPUS-1:0][ADDR_W-1:0]    iaddr,
    output logic [CPUS-1:0]                iwait,
    output logic [CPUS-1:0][ADDR_W-1:0]    iload,
    input  logic [CPUS-1:0]                dREN,
    input  logic [CPUS-1:0]                dWEN,
    input  logic [CPUS-1:0][ADDR_W-1:0]    daddr,
    input  logic [CPUS-1:0][ADDR_W-1:0]    dstore,
    input  logic [CPUS-1:0]                cctrans,
    input  logic [CPUS-1:0]                ccwrite,
    output logic [CPUS-1:0]                dwait,
    output logic [CPUS-1:0][ADDR_W-1:0]    dload,
    output logic [CPUS-1:0]                ccwait,
    output logic [CPUS-1:0]                ccinv,
    output logic [CPUS-1:0][ADDR_W-1:0]    ccsnoopaddr,
    output logic                           ramREN,
    output logic                           ramWEN,
    output logic [ADDR_W-1:0]              ramaddr,
    output logic [ADDR_W-1:0]              ramstore,
    input  logic [ADDR_W-1:0]              ramload,
    input  logic                           ram_ready
);

    typedef enum logic [3:0] {
        IDLE, SNOOP, C2C, DRD_T, DRD, DWB, ACK, ACK_WAIT, IFETCH
    } state_t;

    state_t              state;
    logic                req;         // core owning the current transaction
    logic                oth;         // the other (snooped) core
    logic                last_grant;
    logic                wcount;      // word index within a C2C block
    logic                inv_q;       // invalidate latched at snoop, held to the end
    logic [ADDR_W-4:0]   blk;         // block address latched at snoop

    logic                grant;
    logic                gnt_core;
    state_t              gnt_state;
    logic [CPUS-1:0]     dwb_m;
    logic [CPUS-1:0]     drd_m;
    logic [ADDR_W-1:0]   blk_addr;

    assign oth      = ~req;
    assign blk_addr = {blk, 3'b000};

    // A lone requester wins; a tie goes to the core not granted last.
    function automatic logic pick(input logic [1:0] m, input logic lg);
        return (m == 2'b11) ? ~lg : m[1];
    endfunction

    always_comb begin
        grant     = 1'b0;
        gnt_core  = 1'b0;
        gnt_state = IDLE;
        dwb_m     = dWEN & ~cctrans;
        drd_m     = dREN & ~cctrans;
        if (|cctrans) begin
            grant     = 1'b1;
            gnt_core  = pick(cctrans, last_grant);
            gnt_state = SNOOP;
        end else if (|dwb_m) begin
            grant     = 1'b1;
            gnt_core  = pick(dwb_m, last_grant);
            gnt_state = DWB;
        end else if (|drd_m) begin
            grant     = 1'b1;
            gnt_core  = pick(drd_m, last_grant);
            gnt_state = DRD;
        end else if (|iREN) begin
            grant     = 1'b1;
            gnt_core  = pick(iREN, last_grant);
            gnt_state = IFETCH;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            req        <= 1'b0;
            last_grant <= 1'b1;
            wcount     <= 1'b0;
            inv_q      <= 1'b0;
            blk        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state      <= gnt_state;
                        req        <= gnt_core;
                        last_grant <= gnt_core;
                        wcount     <= 1'b0;
                        inv_q      <= 1'b0;
                    end
                end
                SNOOP: begin
                    inv_q <= dWEN[req];
                    blk   <= daddr[req][ADDR_W-1:3];
                    if (ccwrite[oth])
                        state <= C2C;
                    else if (dREN[req])
                        state <= DRD_T;
                    else
                        state <= ACK;
                end
                C2C: begin
                    if (ram_ready) begin
                        if (wcount) begin
                            wcount <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            wcount <= 1'b1;
                        end
                    end
                end
                DRD_T: begin
                    if (!cctrans[req])
                        state <= IDLE;
                end
                DRD: begin
                    if (!dREN[req] || ram_ready)
                        state <= IDLE;
                end
                DWB: begin
                    if (!dWEN[req] || ram_ready)
                        state <= IDLE;
                end
                ACK: begin
                    state <= cctrans[req] ? ACK_WAIT : IDLE;
                end
                ACK_WAIT: begin
                    if (!cctrans[req])
                        state <= IDLE;
                end
                IFETCH: begin
                    if (ram_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        iwait       = '1;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iload       = {ramload, ramload};
        dload       = {ramload, ramload};
        case (state)
            SNOOP: begin
                ccwait[oth]      = 1'b1;
                ccsnoopaddr[oth] = {daddr[req][ADDR_W-1:3], 3'b000};
                ccinv[oth]       = dWEN[req];
            end
            C2C: begin
                // Dirty data from the snooped cache goes to the requester
                // and to RAM in the same cycle.
                ccwait[oth]      = 1'b1;
                ccsnoopaddr[oth] = blk_addr;
                ccinv[oth]       = inv_q;
                ramWEN           = 1'b1;
                ramaddr          = {blk, wcount, 2'b00};
                ramstore         = dstore[oth];
                dload[req]       = dstore[oth];
                if (ram_ready)
                    dwait = '0;
            end
            DRD_T: begin
                // Enables are gated by cctrans so the release cycle is quiet.
                ccsnoopaddr[oth] = blk_addr;
                ccinv[oth]       = inv_q;
                ramREN           = dREN[req] & cctrans[req];
                ramWEN           = dWEN[req] & cctrans[req];
                ramaddr          = daddr[req];
                ramstore         = dstore[req];
                dwait[req]       = ~ram_ready;
            end
            DRD, DWB: begin
                ramREN     = dREN[req];
                ramWEN     = dWEN[req];
                ramaddr    = daddr[req];
                ramstore   = dstore[req];
                dwait[req] = ~ram_ready;
            end
            ACK: begin
                ccsnoopaddr[oth] = blk_addr;
                ccinv[oth]       = inv_q;
                dwait[req]       = 1'b0;
            end
            ACK_WAIT: begin
                ccsnoopaddr[oth] = blk_addr;
                ccinv[oth]       = inv_q;
            end
            IFETCH: begin
                ramREN     = 1'b1;
                ramaddr    = iaddr[req];
                iwait[req] = ~ram_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl
//   Directed per-cycle vector table for coherence_bus_ctrl plus a
//   hand-written asynchronous-reset-during-C2C sequence.
module tb_coherence_bus_ctrl;

    logic              CLK;
    logic              RST;
    logic [1:0]        iREN;
    logic [1:0][31:0]  iaddr;
    logic [1:0]        iwait;
    logic [1:0][31:0]  iload;
    logic [1:0]        dREN;
    logic [1:0]        dWEN;
    logic [1:0][31:0]  daddr;
    logic [1:0][31:0]  dstore;
    logic [1:0]        cctrans;
    logic [1:0]        ccwrite;
    logic [1:0]        dwait;
    logic [1:0][31:0]  dload;
    logic [1:0]        ccwait;
    logic [1:0]        ccinv;
    logic [1:0][31:0]  ccsnoopaddr;
    logic              ramREN;
    logic              ramWEN;
    logic [31:0]       ramaddr;
    logic [31:0]       ramstore;
    logic [31:0]       ramload;
    logic              ram_ready;

    coherence_bus_ctrl #(.ADDR_W(32), .CPUS(2)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  iren, dren, dwen, cct, ccw;
        logic [31:0] da0, da1, ds1;
        logic        rdy;
        logic [31:0] rl;
        logic [1:0]  e_iw, e_dw, e_ccw, e_inv;
        logic        e_ren, e_wen;
        logic [31:0] e_ra, e_rs, e_snp0, e_snp1, e_dl0;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [319:0] got, input logic [319:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic add(input logic [1:0] iren, input logic [1:0] dren, input logic [1:0] dwen,
                       input logic [1:0] cct, input logic [1:0] ccw,
                       input logic [31:0] da0, input logic [31:0] da1, input logic [31:0] ds1,
                       input logic rdy, input logic [31:0] rl,
                       input logic [1:0] e_iw, input logic [1:0] e_dw, input logic [1:0] e_ccw,
                       input logic [1:0] e_inv, input logic e_ren, input logic e_wen,
                       input logic [31:0] e_ra, input logic [31:0] e_rs,
                       input logic [31:0] e_snp0, input logic [31:0] e_snp1, input logic [31:0] e_dl0);
        vec_t v;
        v.iren = iren; v.dren = dren; v.dwen = dwen; v.cct = cct; v.ccw = ccw;
        v.da0 = da0; v.da1 = da1; v.ds1 = ds1; v.rdy = rdy; v.rl = rl;
        v.e_iw = e_iw; v.e_dw = e_dw; v.e_ccw = e_ccw; v.e_inv = e_inv;
        v.e_ren = e_ren; v.e_wen = e_wen; v.e_ra = e_ra; v.e_rs = e_rs;
        v.e_snp0 = e_snp0; v.e_snp1 = e_snp1; v.e_dl0 = e_dl0;
        vecs.push_back(v);
    endtask

    // IDLE cycle: all outputs at their defaults, RAM idle.
    task automatic add_idle(input logic [1:0] iren, input logic [1:0] dren, input logic [1:0] dwen,
                            input logic [1:0] cct, input logic [31:0] da0, input logic [31:0] da1);
        add(iren, dren, dwen, cct, 2'b00, da0, da1, 32'h0, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    function automatic logic [319:0] outs();
        return {iwait, dwait, ccwait, ccinv, ramREN, ramWEN, 4'h0, ramaddr, ramstore,
                ccsnoopaddr[0], ccsnoopaddr[1], dload[0], dload[1], iload[0], iload[1]};
    endfunction

    logic [319:0] reset_outs;

    initial begin
        RST = 1'b1;
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        iaddr[0] = 32'h100; iaddr[1] = 32'h300;
        daddr = '0; dstore[0] = 32'h5; dstore[1] = '0;
        ramload = '0; ram_ready = 1'b0;

        // Two simultaneous ifetch pairs: core0 first each time
        add_idle(2'b11, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 32'hA0,
            2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 32'hA0);
        add_idle(2'b10, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        add(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 32'hA1,
            2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0, 32'hA1);
        add_idle(2'b11, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 32'hA2,
            2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 32'hA2);
        add_idle(2'b10, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        add(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 32'hA3,
            2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0, 32'hA3);
        // Core0 ifetch at 0x100, RAM ready after 2 wait cycles
        add_idle(2'b01, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0);
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0);
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF,
            2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF);
        add_idle(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        // Core0 read miss at 0x40, core1 dirty: cache-to-cache transfer
        add_idle(2'b00, 2'b01, 2'b00, 2'b01, 32'h40, 32'h0);
        add(2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 32'h40, 32'h0, 32'h11, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h40, 32'h0);
        add(2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 32'h40, 32'h0, 32'h11, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b10, 2'b00, 1'b0, 1'b1, 32'h40, 32'h11, 32'h0, 32'h40, 32'h11);
        add(2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 32'h40, 32'h0, 32'h11, 1'b1, 32'h0,
            2'b11, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 32'h40, 32'h11, 32'h0, 32'h40, 32'h11);
        add(2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 32'h40, 32'h0, 32'h22, 1'b1, 32'h0,
            2'b11, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 32'h44, 32'h22, 32'h0, 32'h40, 32'h22);
        add_idle(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        // Core1 upgrade at 0x8C (block 0x88), core0 clean: invalidate, ack, no RAM
        add_idle(2'b00, 2'b00, 2'b10, 2'b10, 32'h0, 32'h8C);
        add(2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 32'h0, 32'h8C, 32'h0, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b01, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 32'h88, 32'h0, 32'h0);
        add(2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 32'h0, 32'h8C, 32'h0, 1'b0, 32'h0,
            2'b11, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 32'h88, 32'h0, 32'h0);
        add(2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 32'h0, 32'h8C, 32'h0, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 32'h88, 32'h0, 32'h0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h8C, 32'h0, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 32'h88, 32'h0, 32'h0);
        add_idle(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        // Core0 writeback 0x200 <- 5 beats pending core1 ifetch
        add_idle(2'b10, 2'b00, 2'b01, 2'b00, 32'h200, 32'h0);
        add(2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 32'h200, 32'h0, 32'h0, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 32'h200, 32'h5, 32'h0, 32'h0, 32'h0);
        add(2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 32'h200, 32'h0, 32'h0, 1'b1, 32'h0,
            2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 32'h200, 32'h5, 32'h0, 32'h0, 32'h0);
        add_idle(2'b10, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        add(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 32'h77,
            2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0, 32'h77);
        add_idle(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        // Core1 read granted then dropped: no RAM enable, back to IDLE
        add_idle(2'b00, 2'b10, 2'b00, 2'b00, 32'h0, 32'h120);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h120, 32'h0, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h120, 32'h0, 32'h0, 32'h0, 32'h0);
        add_idle(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        // Core1 coherent read, core0 clean: requester-driven 2-word read
        add_idle(2'b00, 2'b10, 2'b00, 2'b10, 32'h0, 32'h48);
        add(2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 32'h0, 32'h48, 32'h0, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h48, 32'h0, 32'h0);
        add(2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 32'h0, 32'h48, 32'h0, 1'b1, 32'h55,
            2'b11, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 32'h48, 32'h0, 32'h48, 32'h0, 32'h55);
        add(2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 32'h0, 32'h4C, 32'h0, 1'b1, 32'h66,
            2'b11, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 32'h4C, 32'h0, 32'h48, 32'h0, 32'h66);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h4C, 32'h0, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h4C, 32'h0, 32'h48, 32'h0, 32'h0);
        add_idle(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        // Simultaneous cctrans: core0 first (last_grant=1), core1 waits
        add_idle(2'b00, 2'b11, 2'b00, 2'b11, 32'h40, 32'h80);
        add(2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 32'h40, 32'h80, 32'h0, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h40, 32'h0);
        add(2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 32'h40, 32'h80, 32'h0, 1'b1, 32'h9,
            2'b11, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 32'h40, 32'h5, 32'h0, 32'h40, 32'h9);
        add(2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 32'h40, 32'h80, 32'h0, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h40, 32'h5, 32'h0, 32'h40, 32'h0);
        add_idle(2'b00, 2'b10, 2'b00, 2'b10, 32'h40, 32'h80);
        add(2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 32'h40, 32'h80, 32'h0, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h80, 32'h0, 32'h0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h40, 32'h80, 32'h0, 1'b0, 32'h0,
            2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h80, 32'h0, 32'h80, 32'h0, 32'h0);
        add_idle(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);

        reset_outs = {2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                      32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

        #2;
        check("reset_state", outs(), reset_outs);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        foreach (vecs[i]) begin
            @(posedge CLK);
            #1;
            iREN = vecs[i].iren; dREN = vecs[i].dren; dWEN = vecs[i].dwen;
            cctrans = vecs[i].cct; ccwrite = vecs[i].ccw;
            daddr[0] = vecs[i].da0; daddr[1] = vecs[i].da1; dstore[1] = vecs[i].ds1;
            ram_ready = vecs[i].rdy; ramload = vecs[i].rl;
            @(negedge CLK);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].e_iw, vecs[i].e_dw, vecs[i].e_ccw, vecs[i].e_inv,
                   vecs[i].e_ren, vecs[i].e_wen, 4'h0, vecs[i].e_ra, vecs[i].e_rs,
                   vecs[i].e_snp0, vecs[i].e_snp1, vecs[i].e_dl0, vecs[i].rl,
                   vecs[i].rl, vecs[i].rl});
        end

        // Reset asserted during C2C word 0
        @(posedge CLK); #1;
        cctrans = 2'b01; dREN = 2'b01; daddr[0] = 32'h40;
        ccwrite = 2'b10; dstore[1] = 32'h11; ram_ready = 1'b0; ramload = '0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("c2c_before_reset", {ramWEN, ramaddr, ramstore}, {1'b1, 32'h40, 32'h11});
        #2;
        RST = 1'b1;
        #1;
        check("async_reset_outs", outs(), reset_outs);
        @(posedge CLK); #1;
        check("reset_held_no_wen", {ramWEN, ramREN}, 2'b00);
        #2;
        RST = 1'b0;
        cctrans = '0; dREN = '0; ccwrite = '0;
        @(posedge CLK); #1;
        check("after_reset_no_wen", outs(), reset_outs);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
